// File: rtl/rv32_fetch_stage.sv
// RV32 instruction fetch: credit-limited imem requests, in-order response FIFO, redirect flush.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched/perf_dropped counters.
module rv32_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = 16;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [DW-1:0] drop_cnt;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          req_fire;
    logic          rsp_stale;
    logic          push;
    logic          pop;
    logic [31:0]   rsp_pc;

    assign fifo_count     = wr_ptr - rd_ptr;
    assign fifo_empty     = (fifo_count == '0);
    assign imem_req_valid = !rst && !redirect_valid &&
                            (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_W);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_stale      = (drop_cnt != '0) || redirect_valid;
    assign push           = imem_rsp_valid && !rsp_stale;
    assign pop            = out_valid && out_ready && !redirect_valid;

    // outstanding counts only live requests, all issued sequentially since the last
    // redirect, so the oldest one's pc is pc - 4*outstanding (this acts as the pc queue).
    assign rsp_pc = pc - {{(30-CW){1'b0}}, outstanding, 2'b00};

    assign out_valid = !fifo_empty;
    assign out_instr = fifo_empty ? '0 : fifo_instr[rd_ptr[AW-1:0]];
    assign out_pc    = fifo_empty ? '0 : fifo_pc[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_valid) begin
            // Every live in-flight request turns stale; the response arriving now is discarded.
            pc          <= redirect_pc & 32'hFFFF_FFFC;
            outstanding <= '0;
            drop_cnt    <= drop_cnt + DW'(outstanding) - DW'(imem_rsp_valid);
            rd_ptr      <= wr_ptr;
        end else begin
            if (req_fire)
                pc <= pc + 32'd4;
            outstanding <= outstanding + CW'(req_fire) - CW'(push);
            if (imem_rsp_valid && drop_cnt != '0)
                drop_cnt <= drop_cnt - DW'(1);
            if (push)
                wr_ptr <= wr_ptr + CW'(1);
            if (pop)
                rd_ptr <= rd_ptr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr[AW-1:0]] <= imem_rsp_data;
            fifo_pc[wr_ptr[AW-1:0]]    <= rsp_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Entries handed to decode in the redirect cycle itself are not counted as flushed.
    logic [31:0] flushed;
    assign flushed = redirect_valid ? (32'(fifo_count) - 32'(out_valid && out_ready)) : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_dropped <= perf_dropped + 32'(imem_rsp_valid && rsp_stale) + flushed;
        end
    end
`endif

    a_credit: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, fifo_count} + {1'b0, outstanding}) <= DEPTH_W);

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// Randomized self-checking bench for rv32_fetch_stage against an epoch-tagged memory/scoreboard model.
module tb_rv32_fetch_stage;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    always #5 clk = ~clk;

    rv32_fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped),
`endif
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int epoch = 0;
    int lat = 1;
    int ready_pct = 100;
    int oready_pct = 100;
    int exp_fetched = 0;
    int exp_dropped = 0;
    logic [31:0] model_pc;
    logic [31:0] fl_addr[$];
    int          fl_due[$];
    int          fl_epoch[$];
    logic [31:0] sb_pc[$];
    logic [31:0] sb_instr[$];
    logic [31:0] popped[$];
    logic        exp_rv;
    logic        exp_ov;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic int live_count();
        int n = 0;
        foreach (fl_epoch[i]) if (fl_epoch[i] == epoch) n++;
        return n;
    endfunction

    // Memory and decode side: drive this cycle's inputs just after the falling edge.
    task automatic drive();
        imem_req_ready = ($urandom_range(99) < ready_pct);
        out_ready      = ($urandom_range(99) < oready_pct);
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (!rst && fl_addr.size() > 0 && fl_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(fl_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic sample();
        #1;
        exp_rv    = !rst && !redirect_valid && (sb_pc.size() + live_count() < DEPTH);
        exp_ov    = (sb_pc.size() != 0);
        exp_pc    = exp_ov ? sb_pc[0] : 32'h0;
        exp_instr = exp_ov ? sb_instr[0] : 32'h0;
    endtask

    // Commit this cycle's handshakes into the model, then move to the next cycle.
    task automatic advance();
        logic acc;
        logic hs;
        acc = imem_req_valid && imem_req_ready;
        hs  = out_valid && out_ready;
        if (hs && sb_pc.size() > 0) begin
            if (!redirect_valid) popped.push_back(sb_pc[0]);
            void'(sb_pc.pop_front());
            void'(sb_instr.pop_front());
        end
        if (imem_rsp_valid && fl_addr.size() > 0) begin
            if (fl_epoch[0] == epoch && !redirect_valid) begin
                sb_pc.push_back(fl_addr[0]);
                sb_instr.push_back(mem_word(fl_addr[0]));
                exp_fetched++;
            end else begin
                exp_dropped++;
            end
            void'(fl_addr.pop_front());
            void'(fl_due.pop_front());
            void'(fl_epoch.pop_front());
        end
        if (redirect_valid) begin
            exp_dropped += sb_pc.size();
            sb_pc.delete();
            sb_instr.delete();
            epoch++;
            model_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        if (acc) begin
            fl_addr.push_back(imem_req_addr);
            fl_due.push_back(cyc + lat);
            fl_epoch.push_back(epoch);
            model_pc = model_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drive();
    endtask

    task automatic clear_model();
        fl_addr.delete(); fl_due.delete(); fl_epoch.delete();
        sb_pc.delete(); sb_instr.delete(); popped.delete();
        model_pc = RST_PC;
        exp_fetched = 0;
        exp_dropped = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        drive();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        drive();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        drive();
        sample();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_req_valid got=%0b exp=0", imem_req_valid); end
        n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_out_pc got=%h exp=0", out_pc); end
        n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_out_instr got=%h exp=0", out_instr); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (perf_fetched !== 32'h0 || perf_dropped !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_perf got=%0d/%0d exp=0/0", perf_fetched, perf_dropped); end
`endif
        advance();
        rst = 1'b0;
        drive();
        sample();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin n_bad++; $display("[TB] FAIL first_req got=%0b/%h exp=1/%h", imem_req_valid, imem_req_addr, RST_PC); end
    endtask

    task automatic test_stream();
        int first_acc = -1;
        int first_ov = -1;
        lat = 1; ready_pct = 100; oready_pct = 100;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            sample();
            if (first_acc < 0 && imem_req_valid && imem_req_ready) first_acc = cyc;
            if (first_ov < 0 && out_valid) first_ov = cyc;
            n_cmp++; if (imem_req_valid !== exp_rv) begin n_bad++; $display("[TB] FAIL stream_req_valid cyc=%0d got=%0b exp=%0b", cyc, imem_req_valid, exp_rv); end
            n_cmp++; if (out_valid !== exp_ov) begin n_bad++; $display("[TB] FAIL stream_out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, exp_ov); end
            n_cmp++; if (out_pc !== exp_pc || out_instr !== exp_instr) begin n_bad++; $display("[TB] FAIL stream_payload cyc=%0d got=%h/%h exp=%h/%h", cyc, out_pc, out_instr, exp_pc, exp_instr); end
            if (imem_req_valid && imem_req_ready) begin
                n_cmp++; if (imem_req_addr !== model_pc) begin n_bad++; $display("[TB] FAIL stream_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, model_pc); end
            end
            advance();
        end
        n_cmp++; if (first_ov - first_acc !== 2) begin n_bad++; $display("[TB] FAIL stream_latency got=%0d exp=2", first_ov - first_acc); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= popped.size() || popped[i] !== 32'(4*i)) begin
                n_bad++; $display("[TB] FAIL stream_order idx=%0d got=%h exp=%h", i, (i < popped.size()) ? popped[i] : 32'hx, 32'(4*i));
            end
        end
    endtask

    task automatic test_backpressure();
        int accepts = 0;
        lat = 1; ready_pct = 100; oready_pct = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            sample();
            if (imem_req_valid && imem_req_ready) accepts++;
            n_cmp++; if (imem_req_valid !== exp_rv || out_valid !== exp_ov) begin n_bad++; $display("[TB] FAIL bp_valids cyc=%0d got=%0b%0b exp=%0b%0b", cyc, imem_req_valid, out_valid, exp_rv, exp_ov); end
            advance();
        end
        n_cmp++; if (accepts !== DEPTH) begin n_bad++; $display("[TB] FAIL bp_accepts got=%0d exp=%0d", accepts, DEPTH); end
        oready_pct = 100;
        drive();
        for (int i = 0; i < 20 && popped.size() < 2; i++) begin
            sample();
            advance();
        end
        n_cmp++; if (popped.size() < 2 || popped[0] !== 32'h0 || popped[1] !== 32'h4) begin n_bad++; $display("[TB] FAIL bp_drain got_count=%0d exp=pcs 0,4", popped.size()); end
    endtask

    task automatic test_redirect_stale();
        int waited = 0;
        logic [31:0] base;
        lat = 3; ready_pct = 100; oready_pct = 100;
        do_reset();
        while (!(live_count() == 2 && !imem_rsp_valid && model_pc == 32'h10) && waited < 40) begin
            sample();
            advance();
            waited++;
        end
        n_cmp++; if (waited >= 40) begin n_bad++; $display("[TB] FAIL stale_setup timeout got=%0d exp<40", waited); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        sample();
`ifdef FETCH_PERF_CNT_EN
        base = perf_dropped;
`else
        base = 32'h0;
`endif
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL stale_req_in_redirect got=%0b exp=0", imem_req_valid); end
        advance();
        popped.delete();
        for (int i = 0; i < 30 && popped.size() < 1; i++) begin
            sample();
            advance();
        end
        n_cmp++; if (popped.size() < 1 || popped[0] !== 32'h100) begin n_bad++; $display("[TB] FAIL stale_next_pc got=%h exp=00000100", (popped.size() > 0) ? popped[0] : 32'hx); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (perf_dropped - base !== 32'd2) begin n_bad++; $display("[TB] FAIL stale_perf_dropped got=%0d exp=2", perf_dropped - base); end
`else
        if (base != 32'h0) $display("[TB] note base=%h", base);
`endif
    endtask

    task automatic test_redirect_coincident();
        int waited = 0;
        lat = 2; ready_pct = 100; oready_pct = 100;
        do_reset();
        while (!(imem_rsp_valid && fl_epoch.size() > 0 && fl_epoch[0] == epoch) && waited < 40) begin
            sample();
            advance();
            waited++;
        end
        n_cmp++; if (waited >= 40) begin n_bad++; $display("[TB] FAIL coinc_setup timeout got=%0d exp<40", waited); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        sample();
        advance();
        sample();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL coinc_flush got=%0b exp=0", out_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_bad++; $display("[TB] FAIL coinc_resume got=%0b/%h exp=1/00000200", imem_req_valid, imem_req_addr); end
        popped.delete();
        for (int i = 0; i < 30 && popped.size() < 1; i++) begin
            advance();
            sample();
        end
        n_cmp++; if (popped.size() < 1 || popped[0] !== 32'h200) begin n_bad++; $display("[TB] FAIL coinc_next_pc got=%h exp=00000200", (popped.size() > 0) ? popped[0] : 32'hx); end
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        lat = 1; ready_pct = 100; oready_pct = 100;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        sample();
        advance();
        popped.delete();
        for (int i = 0; i < 40 && popped.size() < 3; i++) begin
            sample();
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= popped.size() || popped[i] !== want[i]) begin
                n_bad++; $display("[TB] FAIL wrap_pc idx=%0d got=%h exp=%h", i, (i < popped.size()) ? popped[i] : 32'hx, want[i]);
            end
        end
    endtask

    task automatic test_midreset();
        lat = 4; ready_pct = 100; oready_pct = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            sample();
            advance();
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_setup got=%0b exp=1", out_valid); end
        rst = 1'b1;
        clear_model();
        drive();
        sample();
        n_cmp++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_clear got=%0b/%0b exp=0/0", out_valid, imem_req_valid); end
        advance();
        rst = 1'b0;
        oready_pct = 100;
        drive();
        for (int i = 0; i < 30 && popped.size() < 1; i++) begin
            sample();
            advance();
        end
        n_cmp++; if (popped.size() < 1 || popped[0] !== RST_PC) begin n_bad++; $display("[TB] FAIL midrst_restart got=%h exp=%h", (popped.size() > 0) ? popped[0] : 32'hx, RST_PC); end
    endtask

    task automatic test_random();
        lat = 1; ready_pct = 70; oready_pct = 70;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 16 == 0) begin
                lat        = int'($urandom_range(4, 1));
                ready_pct  = int'($urandom_range(100, 20));
                oready_pct = int'($urandom_range(100, 20));
            end
            if ($urandom_range(99) < 6) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            sample();
            n_cmp++; if (imem_req_valid !== exp_rv) begin n_bad++; $display("[TB] FAIL rand_req_valid cyc=%0d got=%0b exp=%0b", cyc, imem_req_valid, exp_rv); end
            n_cmp++; if (out_valid !== exp_ov) begin n_bad++; $display("[TB] FAIL rand_out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, exp_ov); end
            n_cmp++; if (out_pc !== exp_pc || out_instr !== exp_instr) begin n_bad++; $display("[TB] FAIL rand_payload cyc=%0d got=%h/%h exp=%h/%h", cyc, out_pc, out_instr, exp_pc, exp_instr); end
            if (imem_req_valid && imem_req_ready) begin
                n_cmp++; if (imem_req_addr !== model_pc) begin n_bad++; $display("[TB] FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, model_pc); end
            end
            advance();
        end
        sample();
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (perf_fetched !== 32'(exp_fetched)) begin n_bad++; $display("[TB] FAIL rand_perf_fetched got=%0d exp=%0d", perf_fetched, exp_fetched); end
        n_cmp++; if (perf_dropped !== 32'(exp_dropped)) begin n_bad++; $display("[TB] FAIL rand_perf_dropped got=%0d exp=%0d", perf_dropped, exp_dropped); end
`endif
    endtask

    initial begin
        model_pc = RST_PC;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_coincident();
        test_wrap();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
